// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side consumer of the dual-clock FIFO (read-clock domain).
// Pops words from the FIFO and presents them as a valid/ready stream. A 2-entry
// skid buffer absorbs the FIFO's 1-cycle read latency, so the stream can run at
// one word per clock without dropping or duplicating a word.
// Optional feature: define FIFO_RD_STREAM_CNT_EN to add parameter CNTSIZE, port
// DCNT_O and a wrapping counter of delivered words.
module fifo_rd_stream #(
  parameter int DATASIZE = 8
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  parameter int CNTSIZE  = 16
`endif
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  output logic                RINC_O,
  input  logic [DATASIZE-1:0] RDATA_I,
  input  logic                REMPTY_I,
  output logic                M_VALID_O,
  output logic [DATASIZE-1:0] M_DATA_O,
  input  logic                M_READY_I
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [CNTSIZE-1:0]  DCNT_O
`endif
);

  // Buffer FSM states are the buffer occupancy.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]          occ_q, occ_d;
  logic                infl_q;
  logic                valid_q;
  logic [DATASIZE-1:0] head_q, head_d;
  logic [DATASIZE-1:0] tail_q, tail_d;
  logic                xfer;
  logic [2:0]          level;

  assign M_VALID_O = valid_q;
  assign M_DATA_O  = head_q;
  assign xfer      = valid_q & M_READY_I;

  // Words held or arriving once this cycle's transfer leaves; a new read is
  // only issued while that leaves room, so occupancy never exceeds two.
  assign level  = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, xfer};
  assign RINC_O = ~REMPTY_I & ~RST_I & (level < 3'd2);

  // Next occupancy and buffer contents: capture the arriving word at the tail,
  // pop the head on transfer; both in one cycle keeps occupancy unchanged.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case (occ_q)
      EMPTY: begin
        if (infl_q) begin
          occ_d  = ONE;
          head_d = RDATA_I;
        end
      end
      ONE: begin
        if (infl_q && !xfer) begin
          occ_d  = TWO;
          tail_d = RDATA_I;
        end else if (xfer && !infl_q) begin
          occ_d = EMPTY;
        end else if (xfer && infl_q) begin
          head_d = RDATA_I;
        end
      end
      TWO: begin
        if (xfer) begin
          head_d = tail_q;
          if (infl_q) begin
            tail_d = RDATA_I;
          end else begin
            occ_d = ONE;
          end
        end
      end
      default: begin
        occ_d = EMPTY;
      end
    endcase
  end

  // State registers; reset discards buffered and in-flight words.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      occ_q   <= EMPTY;
      infl_q  <= 1'b0;
      valid_q <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      occ_q   <= occ_d;
      infl_q  <= RINC_O;
      valid_q <= (occ_d != EMPTY);
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [CNTSIZE-1:0] dcnt_q;

  assign DCNT_O = dcnt_q;

  // Delivered-word counter, wraps naturally at 2**CNTSIZE.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      dcnt_q <= '0;
    end else if (xfer) begin
      dcnt_q <= dcnt_q + {{(CNTSIZE-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule
